// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: byte-wide RAM/IO port plus the IF and LSB request handshakes.
interface mem_arbiter_if #(parameter int ADDR_WIDTH = 32);
    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;
    logic                  io_buffer_full;
    logic                  if_en;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_done;
    logic [31:0]           if_data;
    logic                  mc_en;
    logic                  mc_wr;
    logic [ADDR_WIDTH-1:0] mc_addr;
    logic [2:0]            mc_len;
    logic [31:0]           mc_w_data;
    logic                  mc_done;
    logic [31:0]           mc_r_data;
    modport master (
        input  mem_din, io_buffer_full, if_en, if_addr, mc_en, mc_wr, mc_addr, mc_len, mc_w_data,
        output mem_dout, mem_a, mem_wr, if_done, if_data, mc_done, mc_r_data
    );
    modport slave (
        output mem_din, io_buffer_full, if_en, if_addr, mc_en, mc_wr, mc_addr, mc_len, mc_w_data,
        input  mem_dout, mem_a, mem_wr, if_done, if_data, mc_done, mc_r_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM/IO port between instruction fetch and the load/store buffer.
// Define MEM_ARB_IO_STALL_EN to defer IO-region stores while the UART buffer is full.
module mem_arbiter #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_SEL     = 2'b11
) (
    input logic           clk,
    input logic           rst,
    input logic           rdy,
    input logic           rollback,
    mem_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;
    state_t                r_state, w_state;
    logic [2:0]            r_stage, w_stage, r_len, w_len;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr, r_mem_a, w_mem_a;
    logic [31:0]           r_wdata, w_wdata, r_acc, w_acc;
    logic [31:0]           r_if_data, w_if_data, r_mc_r_data, w_mc_r_data;
    logic [7:0]            r_mem_dout, w_mem_dout;
    logic                  r_mem_wr, w_mem_wr, r_if_done, w_if_done, r_mc_done, w_mc_done;
    logic                  w_stall, w_go, w_issue, w_last;
    logic [4:0]            w_rd_sh, w_wr_sh;

`ifdef MEM_ARB_IO_STALL_EN
    assign w_stall = bus.mc_en && bus.mc_wr && bus.mc_addr[17:16] == IO_SEL && bus.io_buffer_full;
`else
    logic w_unused_io;
    assign w_unused_io = bus.io_buffer_full ^ (|IO_SEL);
    assign w_stall     = 1'b0;
`endif

    // RAM read data lags its address by two edges, so byte k lands at stage k+2
    assign w_go    = !rollback && !w_stall;
    assign w_issue = r_stage < r_len;
    assign w_last  = r_stage == r_len + 3'd1;
    assign w_rd_sh = {r_stage[1:0] - 2'd2, 3'b000};
    assign w_wr_sh = {r_stage[1:0], 3'b000};

    always_comb begin
        w_state     = r_state;
        w_stage     = r_stage;
        w_len       = r_len;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_acc       = r_acc;
        w_mem_a     = r_mem_a;
        w_mem_dout  = r_mem_dout;
        w_mem_wr    = 1'b0;
        w_if_done   = 1'b0;
        w_mc_done   = 1'b0;
        w_if_data   = r_if_data;
        w_mc_r_data = r_mc_r_data;
        case (r_state)
            IDLE: if (w_go && (bus.mc_en || bus.if_en)) begin
                w_addr     = bus.mc_en ? bus.mc_addr : bus.if_addr;
                w_len      = bus.mc_en ? bus.mc_len : 3'd4;
                w_wdata    = bus.mc_w_data;
                w_acc      = '0;
                w_mem_a    = w_addr;
                w_stage    = 3'd1;
                w_mem_wr   = bus.mc_en && bus.mc_wr;
                w_mem_dout = w_mem_wr ? bus.mc_w_data[7:0] : r_mem_dout;
                w_state    = !bus.mc_en ? IF_RD : bus.mc_wr ? LS_WR : LS_RD;
            end
            IF_RD, LS_RD: if (rollback) begin
                w_state = IDLE;
                w_stage = 3'd0;
                w_mem_a = '0;
            end else begin
                w_acc   = r_stage >= 3'd2 ? r_acc | (32'(bus.mem_din) << w_rd_sh) : r_acc;
                w_mem_a = w_issue ? r_addr + ADDR_WIDTH'(r_stage) : r_mem_a;
                w_stage = r_stage + 3'd1;
                if (w_last) begin
                    w_state     = DONE;
                    w_stage     = 3'd0;
                    w_mem_a     = '0;
                    w_if_done   = r_state == IF_RD;
                    w_mc_done   = r_state == LS_RD;
                    w_if_data   = r_state == IF_RD ? w_acc : r_if_data;
                    w_mc_r_data = r_state == LS_RD ? w_acc : r_mc_r_data;
                end
            end
            // committed stores ignore rollback
            LS_WR: begin
                w_mem_wr   = w_issue;
                w_mem_a    = w_issue ? r_addr + ADDR_WIDTH'(r_stage) : '0;
                w_mem_dout = w_issue ? r_wdata[w_wr_sh +: 8] : r_mem_dout;
                w_stage    = w_issue ? r_stage + 3'd1 : 3'd0;
                w_mc_done  = !w_issue;
                w_state    = w_issue ? LS_WR : DONE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_stage     <= '0;
            r_len       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_acc       <= '0;
            r_mem_a     <= '0;
            r_mem_dout  <= '0;
            r_mem_wr    <= 1'b0;
            r_if_done   <= 1'b0;
            r_mc_done   <= 1'b0;
            r_if_data   <= '0;
            r_mc_r_data <= '0;
        end else if (rdy) begin
            r_state     <= w_state;
            r_stage     <= w_stage;
            r_len       <= w_len;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_acc       <= w_acc;
            r_mem_a     <= w_mem_a;
            r_mem_dout  <= w_mem_dout;
            r_mem_wr    <= w_mem_wr;
            r_if_done   <= w_if_done;
            r_mc_done   <= w_mc_done;
            r_if_data   <= w_if_data;
            r_mc_r_data <= w_mc_r_data;
        end
    end

    assign bus.mem_a     = r_mem_a;
    assign bus.mem_dout  = r_mem_dout;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.if_done   = r_if_done;
    assign bus.if_data   = r_if_data;
    assign bus.mc_done   = r_mc_done;
    assign bus.mc_r_data = r_mc_r_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed requests against a registered-read RAM, checked by a transaction-level model.
module tb_mem_arbiter;
    logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, rollback = 1'b0;
    mem_arbiter_if #(.ADDR_WIDTH(32)) bus();
    mem_arbiter #(.ADDR_WIDTH(32), .IO_SEL(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus)
    );
    always #5 clk = ~clk;

    int cyc = 0, checks = 0, errors = 0;
    int exp_mc_at = -1, exp_if_at = -1, wr_from = -1, wr_to = -1;
    bit exp_mc_rd = 1'b0;
    logic [31:0] exp_mc_data = '0, exp_if_data = '0, r;
    logic [7:0] ram [0:262143];
    logic [7:0] model_mem [0:262143];
    logic pk_en = 1'b0;
    logic [17:0] pk_a = '0;
    logic [7:0] pk_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM shares the core's enable: it samples mem_a on an edge and presents the byte for the next one
    always @(posedge clk) begin
        if (pk_en) ram[pk_a] <= pk_d;
        else if (rdy) begin
            if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
            bus.mem_din <= ram[bus.mem_a[17:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a, input logic [2:0] len);
        logic [31:0] v, x;
        v = '0;
        for (int i = 0; i < int'(len); i++) begin
            x = a + 32'(i);
            v |= 32'(model_mem[x[17:0]]) << (8 * i);
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("mc_done", 32'(bus.mc_done), 32'(cyc == exp_mc_at));
            chk("if_done", 32'(bus.if_done), 32'(cyc == exp_if_at));
            chk("mem_wr", 32'(bus.mem_wr), 32'(cyc >= wr_from && cyc < wr_to));
            if (cyc == exp_mc_at) begin
                chk("mem_a at mc_done", bus.mem_a, 32'h0);
                if (exp_mc_rd) chk("mc_r_data", bus.mc_r_data, exp_mc_data);
            end
            if (cyc == exp_if_at) begin
                chk("mem_a at if_done", bus.mem_a, 32'h0);
                chk("if_data", bus.if_data, exp_if_data);
            end
        end
    end

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        model_mem[a[17:0]] = d;
        pk_a = a[17:0];
        pk_d = d;
        pk_en = 1'b1;
        @(posedge clk); #2;
        pk_en = 1'b0;
    endtask

    task automatic wait_done(input bit want_if, input string nm);
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #2;
            got = want_if ? bus.if_done : bus.mc_done;
        end
        if (!got) chk(nm, 32'h0, 32'h1);
    endtask

    task automatic mc_req(input bit wr, input logic [31:0] a, input logic [2:0] len, input logic [31:0] wd,
                          input int rb_at, input int fr_at, input int fr_n, input int full_n,
                          output logic [31:0] rd);
        int g0, g, e;
        bit got;
        logic [31:0] pa;
        g0 = cyc + 1;
        g = g0;
`ifdef MEM_ARB_IO_STALL_EN
        if (wr && a[17:16] == 2'b11) g = g0 + full_n;
`endif
        exp_mc_rd = !wr;
        exp_mc_data = model_rd(a, len);
        exp_mc_at = g + (wr ? int'(len) : int'(len) + 1) + fr_n;
        if (wr) begin
            wr_from = g;
            wr_to = g + int'(len);
            for (int i = 0; i < int'(len); i++) model_mem[18'(a + 32'(i))] = wd[8*i +: 8];
        end
        bus.mc_wr = wr;
        bus.mc_addr = a;
        bus.mc_len = len;
        bus.mc_w_data = wd;
        bus.mc_en = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            e = cyc + 1;
            rollback = (e == g + rb_at);
            rdy = !(e >= g + fr_at && e < g + fr_at + fr_n);
            bus.io_buffer_full = (e < g0 + full_n);
            pa = bus.mem_a;
            @(posedge clk); #2;
            if (!rdy) chk("frozen mem_a", bus.mem_a, pa);
            got = bus.mc_done;
        end
        if (!got) chk("mc_done timeout", 32'h0, 32'h1);
        rd = bus.mc_r_data;
        bus.mc_en = 1'b0;
        rollback = 1'b0;
        rdy = 1'b1;
        bus.io_buffer_full = 1'b0;
        @(posedge clk); #2;
        wr_from = -1;
        wr_to = -1;
    endtask

    task automatic if_req(input logic [31:0] a, output logic [31:0] rd);
        exp_if_at = cyc + 1 + 5;
        exp_if_data = model_rd(a, 3'd4);
        bus.if_addr = a;
        bus.if_en = 1'b1;
        wait_done(1'b1, "if_done timeout");
        rd = bus.if_data;
        bus.if_en = 1'b0;
        @(posedge clk); #2;
    endtask

    initial begin
        bus.if_en = 1'b0; bus.if_addr = '0; bus.mc_en = 1'b0; bus.mc_wr = 1'b0;
        bus.mc_addr = '0; bus.mc_len = 3'd0; bus.mc_w_data = '0; bus.io_buffer_full = 1'b0;
        #1 rst = 1'b0;
        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
        poke(32'h10, 8'hA5); poke(32'h3FFFF, 8'h77);
        poke(32'h0, 8'h93); poke(32'h1, 8'h00); poke(32'h2, 8'h10); poke(32'h3, 8'h00);
        chk("reset mem_a", bus.mem_a, 32'h0);
        chk("reset mem_dout", 32'(bus.mem_dout), 32'h0);
        chk("reset mem_wr", 32'(bus.mem_wr), 32'h0);
        chk("reset if_done", 32'(bus.if_done), 32'h0);
        chk("reset mc_done", 32'(bus.mc_done), 32'h0);
        chk("reset if_data", bus.if_data, 32'h0);
        chk("reset mc_r_data", bus.mc_r_data, 32'h0);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2;

        mc_req(1'b0, 32'h100, 3'd4, 32'h0, -100, -100, 0, 0, r);
        chk("LW 0x100", r, 32'h44332211);
        mc_req(1'b1, 32'h203, 3'd2, 32'hDEADBEEF, -100, -100, 0, 0, r);
        chk("SH ram[0x203]", 32'(ram[18'h203]), 32'hEF);
        chk("SH ram[0x204]", 32'(ram[18'h204]), 32'hBE);
        mc_req(1'b0, 32'h204, 3'd1, 32'h0, -100, -100, 0, 0, r);
        chk("LBU 0x204", r, 32'h000000BE);
        if_req(32'h0, r);
        chk("IF 0x0", r, 32'h00100093);

        // both requesters at once: LSB first, fetch after the DONE cycle
        exp_mc_at = cyc + 1 + 2; exp_mc_rd = 1'b1; exp_mc_data = model_rd(32'h10, 3'd1);
        exp_if_at = cyc + 1 + 9; exp_if_data = model_rd(32'h0, 3'd4);
        bus.mc_wr = 1'b0; bus.mc_addr = 32'h10; bus.mc_len = 3'd1; bus.mc_en = 1'b1;
        bus.if_addr = 32'h0; bus.if_en = 1'b1;
        wait_done(1'b0, "contention mc timeout");
        chk("contention LB", bus.mc_r_data, 32'h000000A5);
        bus.mc_en = 1'b0;
        wait_done(1'b1, "contention if timeout");
        chk("contention IF", bus.if_data, 32'h00100093);
        bus.if_en = 1'b0;
        @(posedge clk); #2;

        // flush during fetch stage 2: no if_done, arbiter idle right after
        exp_if_at = -1;
        bus.if_addr = 32'h100; bus.if_en = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rollback = 1'b1; bus.if_en = 1'b0;
        @(posedge clk); #2;
        rollback = 1'b0;
        chk("rollback mem_a", bus.mem_a, 32'h0);
        mc_req(1'b0, 32'h100, 3'd1, 32'h0, -100, -100, 0, 0, r);
        chk("LB after rollback", r, 32'h00000011);

        mc_req(1'b1, 32'h40, 3'd4, 32'hCAFEF00D, 1, -100, 0, 0, r);
        mc_req(1'b0, 32'h40, 3'd4, 32'h0, -100, -100, 0, 0, r);
        chk("SW survives rollback", r, 32'hCAFEF00D);
        mc_req(1'b0, 32'h100, 3'd4, 32'h0, -100, 3, 3, 0, r);
        chk("LW with rdy freeze", r, 32'h44332211);
        mc_req(1'b0, 32'h102, 3'd2, 32'h0, -100, -100, 0, 0, r);
        chk("LH unaligned", r, 32'h00004433);
        mc_req(1'b0, 32'hFFFFFFFF, 3'd2, 32'h0, -100, -100, 0, 0, r);
        chk("LH wrap", r, 32'h00009377);
        mc_req(1'b1, 32'h30000, 3'd1, 32'h0000005A, -100, -100, 0, 4, r);
        chk("IO SB ram[0x30000]", 32'(ram[18'h30000]), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
